branch_fb_queue: RTL

BRANCH_FB_QUEUE -- requirements
Module: branch_fb_queue

---
 rtl/branch_fb_queue.sv | 133 +++++++++++++
 1 files changed

// File: rtl/branch_fb_queue.sv
// branch_fb_queue: in-order queue of predicted conditional branches awaiting resolution;
// emits registered predictor-training feedback. Define BRANCH_FB_QUEUE_STATS_EN for statistics counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
    typedef enum logic { NOT_TAKEN = 1'b0, TAKEN = 1'b1 } BranchOutcome;
endpackage

module branch_fb_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int GHR_BITS = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push_valid,
    input  logic [`ADDR_WIDTH-1:0]    i_push_pc,
    input  BranchOutcome              i_push_prediction,
    input  logic [GHR_BITS-1:0]       i_push_ghr,
    output logic                      o_push_ready,
    input  logic                      i_res_valid,
    input  BranchOutcome              i_res_outcome,
    input  logic                      i_flush,
    output logic                      o_fb_valid,
    output logic [`ADDR_WIDTH-1:0]    o_fb_pc,
    output BranchOutcome              o_fb_prediction,
    output BranchOutcome              o_fb_outcome,
    output logic [GHR_BITS-1:0]       o_fb_ghr,
    output logic                      o_mispredict,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_empty,
`ifdef BRANCH_FB_QUEUE_STATS_EN
    output logic [31:0]               o_stat_resolved,
    output logic [31:0]               o_stat_mispredict,
`endif
    output logic                      o_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [`ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    BranchOutcome           pred_mem [DEPTH];
    logic [GHR_BITS-1:0]    ghr_mem  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_pop;
    logic          do_push;
    logic          mis;

    assign o_push_ready = (o_count != CW'(DEPTH));
    assign o_empty      = (o_count == '0);

    // A correct resolve frees the head slot this cycle, so a push is taken even when full;
    // a mispredict squashes everything younger, including a same-cycle push.
    assign do_pop  = !i_flush && i_res_valid && !o_empty;
    assign mis     = do_pop && (pred_mem[head] != i_res_outcome);
    assign do_push = !i_flush && i_push_valid && !mis && (o_push_ready || do_pop);

    // NOTE: entry storage is deliberately not reset; head/tail/count decide which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[tail]   <= i_push_pc;
            pred_mem[tail] <= i_push_prediction;
            ghr_mem[tail]  <= i_push_ghr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head            <= '0;
            tail            <= '0;
            o_count         <= '0;
            o_fb_valid      <= 1'b0;
            o_mispredict    <= 1'b0;
            o_underflow     <= 1'b0;
            o_fb_pc         <= '0;
            o_fb_ghr        <= '0;
            o_fb_prediction <= NOT_TAKEN;
            o_fb_outcome    <= NOT_TAKEN;
        end else if (i_flush) begin
            head         <= '0;
            tail         <= '0;
            o_count      <= '0;
            o_fb_valid   <= 1'b0;
            o_mispredict <= 1'b0;
        end else begin
            o_fb_valid   <= do_pop;
            o_mispredict <= mis;
            if (do_pop) begin
                o_fb_pc         <= pc_mem[head];
                o_fb_prediction <= pred_mem[head];
                o_fb_ghr        <= ghr_mem[head];
                o_fb_outcome    <= i_res_outcome;
            end
            if (i_res_valid && o_empty)
                o_underflow <= 1'b1;
            if (mis) begin
                head    <= tail;
                o_count <= '0;
            end else begin
                if (do_pop)
                    head <= head + PW'(1);
                if (do_push)
                    tail <= tail + PW'(1);
                case ({do_push, do_pop})
                    2'b10:   o_count <= o_count + CW'(1);
                    2'b01:   o_count <= o_count - CW'(1);
                    default: o_count <= o_count;
                endcase
            end
        end
    end

`ifdef BRANCH_FB_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stat_resolved   <= '0;
            o_stat_mispredict <= '0;
        end else begin
            if (o_fb_valid && (o_stat_resolved != '1))
                o_stat_resolved <= o_stat_resolved + 32'd1;
            if (o_mispredict && (o_stat_mispredict != '1))
                o_stat_mispredict <= o_stat_mispredict + 32'd1;
        end
    end
`endif

endmodule
